// File: rtl/branch_flush_pkg.sv
// Branch flush controller shared definitions: transfer type codes,
// type field width and the default bubble depth.
package branch_flush_pkg;

  localparam int BR_TYPE_W           = 4;
  localparam int FLUSH_DEPTH_DEFAULT = 3;

  // Control-transfer type codes as decoded by the resolve stage.
  // Codes 11..15 are unused and behave exactly like BR_NONE.
  typedef enum logic [BR_TYPE_W-1:0] {
    BR_NONE = 4'd0,
    BR_J    = 4'd1,
    BR_JAL  = 4'd2,
    BR_JR   = 4'd3,
    BR_JALR = 4'd4,
    BR_BEQ  = 4'd5,
    BR_BNE  = 4'd6,
    BR_BGEZ = 4'd7,
    BR_BLTZ = 4'd8,
    BR_BGTZ = 4'd9,
    BR_BLEZ = 4'd10
  } br_type_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational taken/not-taken decision for a control transfer, from its
// type code and the comparator flags of the resolve stage.
module branch_cond_eval
  import branch_flush_pkg::*;
(
  input  logic [BR_TYPE_W-1:0] br_type,
  input  logic                 eq,
  input  logic                 rs_neg,
  input  logic                 rs_zero,
  output logic                 taken
);

  // Jumps are unconditional; branches test the flags; unknown codes never take.
  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_J, BR_JAL, BR_JR, BR_JALR: taken = 1'b1;
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = ~eq;
      BR_BGEZ: taken = ~rs_neg;
      BR_BLTZ: taken = rs_neg;
      BR_BGTZ: taken = ~rs_neg & ~rs_zero;
      BR_BLEZ: taken = rs_neg | rs_zero;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_flush_ctrl.sv
// Branch flush controller: accepts taken control transfers, pulses a PC
// redirect and inserts FLUSH_DEPTH bubble cycles with a thermometer flush
// mask. Transfers arriving while bubbles are pending are squashed.
// Optional macro BFC_STATS_EN adds a saturating accepted-transfer counter
// on port taken_cnt.
module branch_flush_ctrl
  import branch_flush_pkg::*;
#(
  parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEFAULT,
  parameter int CNT_W       = 4,
  parameter int STAT_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   br_valid,
  input  logic [BR_TYPE_W-1:0]   br_type,
  input  logic                   eq,
  input  logic                   rs_neg,
  input  logic                   rs_zero,
  input  logic                   stall,
  output logic [CNT_W-1:0]       bubble,
  output logic [FLUSH_DEPTH-1:0] flush,
  output logic                   redirect,
  output logic                   busy
`ifdef BFC_STATS_EN
  ,
  output logic [STAT_W-1:0]      taken_cnt
`endif
);

  logic             taken;
  logic             accept;
  logic [CNT_W-1:0] bubble_q;
  logic [CNT_W-1:0] bubble_d;
  logic             redirect_q;
  logic             redirect_d;

  branch_cond_eval u_cond (
    .br_type (br_type),
    .eq      (eq),
    .rs_neg  (rs_neg),
    .rs_zero (rs_zero),
    .taken   (taken)
  );

  // A transfer is only taken up when no bubbles remain and the pipe moves.
  always_comb begin
    accept = br_valid & taken & (bubble_q == '0) & ~stall;
  end

  // Next bubble count and redirect: stall freezes, accept reloads, else drain.
  always_comb begin
    bubble_d   = bubble_q;
    redirect_d = 1'b0;
    if (stall) begin
      bubble_d = bubble_q;
    end else if (accept) begin
      bubble_d   = CNT_W'(FLUSH_DEPTH);
      redirect_d = 1'b1;
    end else if (bubble_q != '0) begin
      bubble_d = bubble_q - CNT_W'(1);
    end
  end

  // Bubble counter and registered redirect pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q   <= '0;
      redirect_q <= 1'b0;
    end else begin
      bubble_q   <= bubble_d;
      redirect_q <= redirect_d;
    end
  end

  // Thermometer flush mask: stage i is flushed while more than i bubbles remain.
  always_comb begin
    flush = '0;
    for (int i = 0; i < FLUSH_DEPTH; i++) begin
      flush[i] = (bubble_q > CNT_W'(i));
    end
  end

  // Status outputs straight from the counter state.
  always_comb begin
    bubble   = bubble_q;
    busy     = (bubble_q != '0);
    redirect = redirect_q;
  end

`ifdef BFC_STATS_EN
  logic [STAT_W-1:0] taken_cnt_q;
  logic [STAT_W-1:0] taken_cnt_d;

  // Saturating count of accepted transfers.
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    if (accept && (taken_cnt_q != '1)) begin
      taken_cnt_d = taken_cnt_q + STAT_W'(1);
    end
  end

  // Statistics register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
    end
  end

  // Expose the statistics register.
  always_comb begin
    taken_cnt = taken_cnt_q;
  end
`endif

endmodule
